pipelined_select_adder: RTL
===========================

PIPELINED_SELECT_ADDER -- requirements
Module: pipelined_select_adder

Interface
REQ-001 SHALL have parameter N, default 32, operand/result width in bits.
REQ-002 SHALL have parameter STAGES, default 4, pipeline depth; N mod STAGES = 0, STAGES >= 1; segment width W = N/STAGES.
REQ-003 SHALL have parameter SATURATE, default 0; 0 = wrap result, 1 = clamp on signed overflow.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_valid  input  1  operand set present.
REQ-007 SHALL have port in_ready  output  1  operand set accepted when in_valid && in_ready.
REQ-008 SHALL have port in1  input  N  signed two's-complement operand A.
REQ-009 SHALL have port in2  input  N  signed two's-complement operand B.
REQ-010 SHALL have port cin  input  1  carry-in.
REQ-011 SHALL have port out_valid  output  1  result present.
REQ-012 SHALL have port out_ready  input  1  result consumed when out_valid && out_ready.
REQ-013 SHALL have port sum  output  N  result.
REQ-014 SHALL have port cout  output  1  unsigned carry out of bit N-1.
REQ-015 SHALL have port OF  output  1  signed overflow of this result.
REQ-016 SHALL have port of_clr  input  1  synchronous clear of of_count.
REQ-017 SHALL have port of_count  output  16  count of transferred results with OF=1.

Function
REQ-018 SHALL split operands into STAGES segments of W bits; stage k adds segment k only, computing both carry-0 and carry-1 sums and selecting with the registered carry from stage k-1 (stage 0 uses cin).
REQ-019 SHALL register segment results and carry each stage, skewing not-yet-added upper segments and already-added lower sums alongside.
REQ-020 SHALL produce {cout,sum} = in1 + in2 + cin (N+1-bit unsigned) exactly STAGES advancing cycles after acceptance.
REQ-021 SHALL set OF = 1 iff in1[N-1] == in2[N-1] and raw sum[N-1] != in1[N-1].
REQ-022 SHALL, with SATURATE=1 and OF=1, output sum = 0111..1 when operands non-negative and 1000..0 when negative; cout and OF unchanged from raw.
REQ-023 SHALL advance the whole pipeline when adv = !out_valid || out_ready; in_ready = adv; all stage registers hold when adv = 0.
REQ-024 SHALL carry a valid bit per stage; bubbles propagate as bubbles (no compaction); out_valid = last-stage valid bit.
REQ-025 SHALL hold sum, cout, OF stable while out_valid && !out_ready.
REQ-026 SHALL preserve order; no result lost or duplicated under any stall pattern.
REQ-027 SHALL increment of_count on each transfer with OF=1, saturating at 0xFFFF.
REQ-028 SHALL give of_clr priority: of_clr with simultaneous overflow transfer yields of_count = 0.
REQ-029 SHALL sustain one result per cycle when in_valid and out_ready held high.

Reset
REQ-030 SHALL, on rst=1 at a clock edge, clear all valid bits, sum, cout, OF, internal carries and of_count to 0.
REQ-031 SHALL discard in-flight operands on reset mid-operation; out_valid = 0 the cycle after rst, nothing from before reset emerges afterwards.
REQ-032 SHALL drive in_ready = 1 during and after reset (pipeline empty).

Verification (N=32, STAGES=4, out_ready=1 unless stated)
REQ-033 SHALL cover: 0x40000000+0x40000000, cin=0 -> 4 cycles later sum=0x80000000, cout=0, OF=1 (SATURATE=1: sum=0x7FFFFFFF, OF=1).
REQ-034 SHALL cover: 0x80000001+0x80000001, cin=0 -> sum=0x00000002, cout=1, OF=1 (SATURATE=1: sum=0x80000000).
REQ-035 SHALL cover back-to-back: (0x00000001,0x80000000,0),(0xFFFFFFEA,0xFFFFFFEA,0),(2,2,1),(0xDE,0xDE,1) -> consecutive outputs 0x80000001/cout0, 0xFFFFFFD4/cout1, 0x00000005, 0x000001BD, all OF=0.
REQ-036 SHALL cover stall: fill pipeline, out_ready=0 for 5 cycles -> in_ready=0, outputs frozen; release -> remaining results in order, none lost or duplicated.
REQ-037 SHALL cover counter: three overflowing transfers -> of_count=3; of_clr coincident with fourth overflowing transfer -> of_count=0.
REQ-038 SHALL cover reset with two operand sets in flight -> out_valid=0 next cycle, no stale result ever emitted, of_count=0.

Source files
------------

// File: rtl/pipelined_select_adder.sv
// Pipelined carry-select adder: one W-bit segment is added per stage, with the
// carry handed forward in a register; the result can wrap or saturate on signed overflow.
module pipelined_select_adder #(
    parameter int N        = 32,
    parameter int STAGES   = 4,
    parameter int SATURATE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in1,
    input  logic [N-1:0] in2,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         OF,
    input  logic         of_clr,
    output logic [15:0]  of_count
);

    localparam int W    = N / STAGES;
    localparam int LAST = STAGES - 1;

    if (STAGES < 1 || (N % STAGES) != 0) begin : g_param_check
        $error("pipelined_select_adder: N must be a positive multiple of STAGES");
    end

    // The whole pipeline moves in lockstep; a stalled output freezes every stage.
    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Stage k sees x_in = {operand A bits not yet added, sum bits already produced},
    // y_in = operand B bits not yet added, and the carry out of the previous segment.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * W;
        localparam int HI = N - LO;

        logic [N-1:0]  x_in;
        logic [HI-1:0] y_in;
        logic          c_in;
        logic          v_in;

        logic [W-1:0]  seg_a;
        logic [W-1:0]  seg_b;
        logic [W:0]    sum0;
        logic [W:0]    sum1;
        logic [W:0]    sel;
        logic [N-1:0]  x_next;

        assign seg_a = x_in[LO +: W];
        assign seg_b = y_in[W-1:0];
        assign sum0  = {1'b0, seg_a} + {1'b0, seg_b};
        assign sum1  = {1'b0, seg_a} + {1'b0, seg_b} + (W+1)'(1);
        assign sel   = c_in ? sum1 : sum0;

        // NOTE: always_comb assigns a full default before the partial overwrite, so no latch is inferred.
        always_comb begin
            x_next          = x_in;
            x_next[LO +: W] = sel[W-1:0];
        end

        if (k == 0) begin : g_head
            assign x_in = in1;
            assign y_in = in2;
            assign c_in = cin;
            assign v_in = in_valid;
        end else begin : g_body
            // NOTE: control state (valid, carry) is reset; the operand/sum datapath is not, since it is qualified by valid.
            always_ff @(posedge clk) begin
                if (rst) begin
                    v_in <= 1'b0;
                    c_in <= 1'b0;
                end else if (adv) begin
                    v_in <= g_stage[k-1].v_in;
                    c_in <= g_stage[k-1].sel[W];
                end
            end

            always_ff @(posedge clk) begin
                if (adv) begin
                    x_in <= g_stage[k-1].x_next;
                    y_in <= g_stage[k-1].y_in[HI+W-1:W];
                end
            end
        end
    end

    // The top segment is added in the last stage, so its x_in/y_in still carry the operand sign bits.
    logic         a_msb;
    logic         b_msb;
    logic         raw_msb;
    logic         of_raw;
    logic [N-1:0] sat_val;
    logic [N-1:0] final_sum;

    assign a_msb   = g_stage[LAST].x_in[N-1];
    assign b_msb   = g_stage[LAST].y_in[W-1];
    assign raw_msb = g_stage[LAST].sel[W-1];
    assign of_raw  = (a_msb == b_msb) && (raw_msb != a_msb);
    assign sat_val = a_msb ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};

    always_comb begin
        final_sum = g_stage[LAST].x_next;
        if (SATURATE != 0 && of_raw) begin
            final_sum = sat_val;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            OF        <= 1'b0;
        end else if (adv) begin
            out_valid <= g_stage[LAST].v_in;
            if (g_stage[LAST].v_in) begin
                sum  <= final_sum;
                cout <= g_stage[LAST].sel[W];
                OF   <= of_raw;
            end
        end
    end

    // Clear wins over a coincident overflow transfer; the count sticks at its maximum.
    always_ff @(posedge clk) begin
        if (rst || of_clr) begin
            of_count <= '0;
        end else if (out_valid && out_ready && OF && of_count != 16'hFFFF) begin
            of_count <= of_count + 16'd1;
        end
    end

endmodule
